// File: rtl/p_to_s.sv
// rtl/p_to_s.sv - parallel word to serial bit stream converter with a one-word hold buffer
module p_to_s #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_a,
  output logic             ready_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             valid_b,
  input  logic             ready_b,
  output logic             data_b,
  output logic             last_b
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             in_xfer;
  logic             out_xfer;
  logic             word_done;
  logic             load_direct;

  assign ready_a   = !hold_full && !rst;
  assign valid_b   = (state == SHIFT);
  assign data_b    = valid_b && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign last_b    = valid_b && (cnt == CNT_LAST);
  assign in_xfer   = valid_a && ready_a;
  assign out_xfer  = valid_b && ready_b;
  assign word_done = out_xfer && last_b;

  // in_xfer implies an empty hold, so an idle FSM or a finishing word takes data_a straight into shreg.
  assign load_direct   = in_xfer && ((state == IDLE) || word_done);
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      if (load_direct) begin
        shreg <= data_a;
        cnt   <= '0;
        state <= SHIFT;
      end else if (word_done) begin
        cnt <= '0;
        if (hold_full) begin
          shreg     <= hold;
          hold_full <= 1'b0;
        end else begin
          state <= IDLE;
        end
      end else if (out_xfer) begin
        shreg <= shreg_shifted;
        cnt   <= cnt + CW'(1);
      end

      if (in_xfer && !load_direct) begin
        hold      <= data_a;
        hold_full <= 1'b1;
      end
    end
  end

endmodule
